// File: rtl/writeback_pipe_if.sv
// Bundle between the memory stage and the MEM/WB register, including the
// registered write-back outputs seen by the register file and forwarding unit.
interface writeback_pipe_if #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5,
   parameter int CNT_W  = 32
);
   logic              InValid;
   logic              Stall;
   logic              Flush;
   logic [REG_AW-1:0] WriteReg;
   logic              RegWrite;
   logic [1:0]        ResultSrc;
   logic [1:0]        MemSize;
   logic              MemUnsigned;
   logic [DATA_W-1:0] ALUResult;
   logic [DATA_W-1:0] ReadData;
   logic [DATA_W-1:0] LinkAddr;

   logic [DATA_W-1:0] Result;
   logic [REG_AW-1:0] WriteRegOut;
   logic              RegWriteOut;
   logic              ResultValid;
   logic [CNT_W-1:0]  RetireCount;

   // Memory-stage side drives the bundle and observes write-back.
   modport master (
      output InValid, Stall, Flush, WriteReg, RegWrite, ResultSrc, MemSize,
             MemUnsigned, ALUResult, ReadData, LinkAddr,
      input  Result, WriteRegOut, RegWriteOut, ResultValid, RetireCount
   );

   // The pipeline register itself.
   modport slave (
      input  InValid, Stall, Flush, WriteReg, RegWrite, ResultSrc, MemSize,
             MemUnsigned, ALUResult, ReadData, LinkAddr,
      output Result, WriteRegOut, RegWriteOut, ResultValid, RetireCount
   );
endinterface

// File: rtl/writeback_pipe.sv
// MEM/WB pipeline register with write-back source selection, sub-word load
// extraction/extension, valid/stall/flush control and a retired-instruction counter.
module writeback_pipe #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5,
   parameter int CNT_W  = 32
) (
   input  logic           CLK,
   input  logic           Reset,
   writeback_pipe_if.slave bus
);
   localparam int OFF_W = $clog2(DATA_W / 8);
   localparam int NB    = DATA_W / 8;
   localparam int NH    = DATA_W / 16;
   localparam int NW    = DATA_W / 32;

   logic [OFF_W-1:0]  off;
   logic [7:0]        byte_lane [NB];
   logic [15:0]       half_lane [NH];
   logic [31:0]       word_lane [NW];
   logic [7:0]        byte_sel;
   logic [15:0]       half_sel;
   logic [31:0]       word_sel;
   logic [DATA_W-1:0] load_value;
   logic [DATA_W-1:0] wb_value;

   logic [DATA_W-1:0] result_q, result_d;
   logic [REG_AW-1:0] write_reg_q, write_reg_d;
   logic              reg_write_q, reg_write_d;
   logic              valid_q, valid_d;
   logic [CNT_W-1:0]  retire_q, retire_d;

   assign off = bus.ALUResult[OFF_W-1:0];

   genvar gi;
   generate
      for (gi = 0; gi < NB; gi++) begin : g_byte
         assign byte_lane[gi] = bus.ReadData[8*gi +: 8];
      end
      for (gi = 0; gi < NH; gi++) begin : g_half
         assign half_lane[gi] = bus.ReadData[16*gi +: 16];
      end
      for (gi = 0; gi < NW; gi++) begin : g_word
         assign word_lane[gi] = bus.ReadData[32*gi +: 32];
      end
      // A 32-bit datapath has a single word lane and no word-select offset bits.
      if (NW > 1) begin : g_word_mux
         assign word_sel = word_lane[off[OFF_W-1:2]];
      end else begin : g_word_only
         assign word_sel = word_lane[0];
      end
   endgenerate

   // Low offset bits below the access size are ignored: misaligned loads do not trap.
   assign byte_sel = byte_lane[off];
   assign half_sel = half_lane[off[OFF_W-1:1]];

   always_comb begin
      load_value = '0;
      case (bus.MemSize)
         2'b00: begin
            if (bus.MemUnsigned) load_value = DATA_W'(byte_sel);
            else                 load_value = DATA_W'($signed(byte_sel));
         end
         2'b01: begin
            if (bus.MemUnsigned) load_value = DATA_W'(half_sel);
            else                 load_value = DATA_W'($signed(half_sel));
         end
         2'b10: begin
            if (bus.MemUnsigned) load_value = DATA_W'(word_sel);
            else                 load_value = DATA_W'($signed(word_sel));
         end
         default: load_value = bus.ReadData;
      endcase
   end

   always_comb begin
      case (bus.ResultSrc)
         2'b01:   wb_value = load_value;
         2'b10:   wb_value = bus.LinkAddr;
         default: wb_value = bus.ALUResult;
      endcase
   end

   always_comb begin
      result_d    = result_q;
      write_reg_d = write_reg_q;
      reg_write_d = reg_write_q;
      valid_d     = valid_q;
      retire_d    = retire_q;
      if (bus.Flush) begin
         valid_d     = 1'b0;
         reg_write_d = 1'b0;
      end else if (!bus.Stall) begin
         result_d    = wb_value;
         write_reg_d = bus.WriteReg;
         reg_write_d = bus.RegWrite & bus.InValid & (|bus.WriteReg);
         valid_d     = bus.InValid;
         // The instruction currently held is retired as it leaves the stage.
         if (valid_q) retire_d = retire_q + 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (Reset) begin
         result_q    <= '0;
         write_reg_q <= '0;
         reg_write_q <= 1'b0;
         valid_q     <= 1'b0;
         retire_q    <= '0;
      end else begin
         result_q    <= result_d;
         write_reg_q <= write_reg_d;
         reg_write_q <= reg_write_d;
         valid_q     <= valid_d;
         retire_q    <= retire_d;
      end
   end

   assign bus.Result      = result_q;
   assign bus.WriteRegOut = write_reg_q;
   assign bus.RegWriteOut = reg_write_q;
   assign bus.ResultValid = valid_q;
   assign bus.RetireCount = retire_q;
endmodule

// File: doc/writeback_pipe.md
# writeback_pipe

Parametrised MEM/WB pipeline register plus write-back stage for the MIPS core. It captures the memory-stage bundle, selects the write-back source (ALU, load data, or link address) and extracts/extends sub-word loads. It presents a registered result, destination register and write enable to the register file and forwarding unit. Valid/stall/flush control and a retired-instruction counter are included.

## Interface
- DATA_W, 32: datapath width; 32 or 64.
- REG_AW, 5: register-file address width.
- CNT_W, 32: retired-instruction counter width.
- OFF_W, derived as log2(DATA_W/8): byte-offset width. Not overridable.

- CLK  in  1  clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- InValid  in  1  an instruction is present on the inputs this cycle.
- Stall  in  1  hold the stage; inputs are ignored.
- Flush  in  1  discard the captured instruction.
- WriteReg  in  REG_AW  destination register.
- RegWrite  in  1  instruction writes the register file.
- ResultSrc  in  2  00 ALU, 01 memory, 10 link, 11 reserved (treated as ALU).
- MemSize  in  2  00 byte, 01 half, 10 word (32b), 11 full DATA_W.
- MemUnsigned  in  1  zero-extend loads when 1; sign-extend when 0.
- ALUResult  in  DATA_W  ALU result; bits [OFF_W-1:0] are the load byte offset.
- ReadData  in  DATA_W  aligned memory read word, little-endian lanes.
- LinkAddr  in  DATA_W  return address for JAL/JALR.
- Result  out  DATA_W  write-back data.
- WriteRegOut  out  REG_AW  registered destination register.
- RegWriteOut  out  1  register-file write enable.
- ResultValid  out  1  output bundle holds a live instruction.
- RetireCount  out  CNT_W  count of retired instructions.

## Operation
- Source selection and load extraction are combinational on the input side. Only the selected result is registered.
- Load extraction (ResultSrc=01):
  - Byte k occupies ReadData[8k+7:8k].
  - Byte: lane = offset.
  - Half: lane pair = offset with bit 0 cleared.
  - Word: 32-bit lane = offset with bits [1:0] cleared.
  - Full: the whole ReadData; MemUnsigned is ignored.
  - Misaligned offset bits are ignored; there is no trap.
  - The extracted value is zero- or sign-extended to DATA_W.
  - With DATA_W=32, word and full produce identical results.
- Update priority on each edge:
  1. Reset: all registers cleared.
  2. Flush: ResultValid←0, RegWriteOut←0. The other registers may load but are don't-care.
  3. Stall: every register holds its value.
  4. Otherwise: load the bundle and set ResultValid←InValid.
- RegWriteOut is loaded as RegWrite & InValid & (WriteReg≠0). A write to R0 never asserts it.
- When InValid=0 and no stall is active, Result and WriteRegOut may load but are don't-care. RegWriteOut←0.
- RetireCount increments by 1 on every edge where ResultValid=1, the stage is not stalled, and there is no flush or reset.
  - Retirement is counted as the instruction leaves the stage.
  - The counter wraps from 2^CNT_W−1 to 0.
- A bubble, a flushed slot or a held (stalled) slot is never counted.
- A stalled valid instruction is counted once, on the edge it leaves.

## Timing
- Latency is 1 cycle: inputs sampled at edge N appear on the outputs after edge N.
- All outputs are registered; there is no combinational input-to-output path.
- Reset values: Result=0, WriteRegOut=0, RegWriteOut=0, ResultValid=0, RetireCount=0.
- Reset asserted mid-stream takes effect on the next edge and discards the captured instruction. The counter returns to 0.
- Flush and Stall asserted together: the flush wins.
- Stall held for K cycles: the outputs are stable for K+1 cycles. RegWriteOut remains asserted for the whole hold, so the register file rewrites the same value; this is harmless.
- Throughput is one instruction per cycle when Stall=0.

## Test plan
- Reset: hold Reset 2 cycles with random inputs. Required: all outputs 0, RetireCount=0.
- ALU path: InValid=1, RegWrite=1, WriteReg=5, ResultSrc=00, ALUResult=0x1234_5678. Required, one cycle later: Result=0x1234_5678, WriteRegOut=5, RegWriteOut=1, ResultValid=1.
- Loads, DATA_W=32, ReadData=0x8081_F27F:
  - byte, offset 1, signed → 0xFFFF_FFF2.
  - byte, offset 0, unsigned → 0x0000_007F.
  - half, offset 2, signed → 0xFFFF_8081.
  - half, offset 3 → same as offset 2.
  - word → 0x8081_F27F.
- Link and R0: ResultSrc=10, LinkAddr=0x0040_0008, WriteReg=31 → Result=0x0040_0008, RegWriteOut=1. The same with WriteReg=0 → RegWriteOut=0, ResultValid=1.
- Stall and flush:
  - Valid instruction A, then Stall for 3 cycles while B is presented: A is held 4 cycles and RetireCount increments once.
  - Stall and Flush asserted together: ResultValid=0 and RegWriteOut=0 next cycle.
- Counter wrap, CNT_W=4: stream 17 valid instructions. Required: RetireCount passes 15 → 0 and ends at 1 once the last instruction leaves. Bubbles (InValid=0) interleaved do not increment it.
